// File: rtl/frame_score_classifier.sv
// Frame classifier: streams NUM_CELLS feature cells through per-class saturating MACs, then argmax with energy/margin gating.
// Define FSC_VOTE_EN to require VOTE_FRAMES consecutive agreeing passing frames before a result is reported.
module frame_score_classifier #(
    parameter int NUM_CELLS    = 256,
    parameter int NUM_CLASSES  = 4,
    parameter int VALUE_BITS   = 8,
    parameter int WEIGHT_BITS  = 8,
    parameter int SCORE_BITS   = 24,
    parameter int ENERGY_BITS  = 24,
    parameter int READ_LATENCY = 2,
    parameter int MIN_ENERGY   = 100,
    parameter int MIN_MARGIN   = 16,
    parameter int VOTE_FRAMES  = 3,
    localparam int AW = $clog2(NUM_CELLS),
    localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               frame_tick_i,
    output logic                               busy_o,
    output logic [AW-1:0]                      feat_addr_o,
    output logic                               feat_rd_en_o,
    input  logic [VALUE_BITS-1:0]              feat_data_i,
    output logic [AW-1:0]                      w_addr_o,
    input  logic [NUM_CLASSES*WEIGHT_BITS-1:0] w_data_flat_i,
    output logic                               result_valid_o,
    output logic [CW-1:0]                      result_class_o,
    output logic [SCORE_BITS-1:0]              result_margin_o,
    output logic [ENERGY_BITS-1:0]             result_energy_o,
    output logic [NUM_CLASSES*SCORE_BITS-1:0]  scores_flat_o,
    output logic                               frame_dropped_o
);

    localparam int PW = WEIGHT_BITS + VALUE_BITS + 1;
    localparam int SW = ((SCORE_BITS > PW) ? SCORE_BITS : PW) + 1;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-SCORE_BITS+1){1'b0}}, {(SCORE_BITS-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-SCORE_BITS+1){1'b1}}, {(SCORE_BITS-1){1'b0}}};
    localparam logic signed [SCORE_BITS-1:0] SCORE_MIN = {1'b1, {(SCORE_BITS-1){1'b0}}};
    localparam logic [AW-1:0] LAST_CELL  = AW'(NUM_CELLS - 1);
    localparam logic [AW-1:0] LAST_DRAIN = AW'(READ_LATENCY - 1);
    localparam logic [AW-1:0] LAST_CLASS = AW'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, ARGMAX, DECIDE} state_t;

    state_t                        state_q, state_d;
    logic [AW-1:0]                 cnt_q, cnt_d;
    logic [READ_LATENCY-1:0]       vld_q;
    logic signed [SCORE_BITS-1:0]  acc_q    [NUM_CLASSES];
    logic signed [SCORE_BITS-1:0]  acc_d    [NUM_CLASSES];
    logic signed [SCORE_BITS-1:0]  scores_q [NUM_CLASSES];
    logic [ENERGY_BITS-1:0]        energy_q, energy_d;
    logic [ENERGY_BITS:0]          energy_sum;
    logic signed [PW-1:0]          prod;
    logic signed [SCORE_BITS-1:0]  best_q, runner_q, cur_score;
    logic [CW-1:0]                 best_idx_q, cur_idx;
    logic [SCORE_BITS-1:0]         margin;
    logic                          pass, emit;
    logic                          result_valid_q, frame_dropped_q;
    logic [CW-1:0]                 class_q;
    logic [SCORE_BITS-1:0]         margin_q;
    logic [ENERGY_BITS-1:0]        energy_out_q;

    function automatic logic signed [SCORE_BITS-1:0] sat_add(input logic signed [SCORE_BITS-1:0] a,
                                                              input logic signed [PW-1:0] p);
        logic signed [SW-1:0] s;
        s = SW'(a) + SW'(p);
        if (s > SAT_MAX)
            return SAT_MAX[SCORE_BITS-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[SCORE_BITS-1:0];
        return s[SCORE_BITS-1:0];
    endfunction

    // One shared counter walks cells, drain beats and classes; it restarts on every state change.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_tick_i) state_d = SCAN;
            SCAN:    if (cnt_q == LAST_CELL) state_d = DRAIN;
            DRAIN:   if (cnt_q == LAST_DRAIN) state_d = ARGMAX;
            ARGMAX:  if (cnt_q == LAST_CLASS) state_d = DECIDE;
            DECIDE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        prod = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            prod     = PW'($signed(w_data_flat_i[k*WEIGHT_BITS +: WEIGHT_BITS])) * PW'($signed({1'b0, feat_data_i}));
            acc_d[k] = sat_add(acc_q[k], prod);
        end
        energy_sum = {1'b0, energy_q} + (ENERGY_BITS+1)'(feat_data_i);
        energy_d   = energy_sum[ENERGY_BITS] ? '1 : energy_sum[ENERGY_BITS-1:0];
    end

    assign cur_idx   = cnt_q[CW-1:0];
    assign cur_score = acc_q[cur_idx];
    assign margin    = SCORE_BITS'(best_q - runner_q);
    assign pass      = (energy_q >= ENERGY_BITS'(MIN_ENERGY)) && (margin >= SCORE_BITS'(MIN_MARGIN));

`ifdef FSC_VOTE_EN
    logic [3:0]    run_q, run_d;
    logic [CW-1:0] run_class_q;
    logic          restart;

    // A run only pulses on the frame that lands exactly on VOTE_FRAMES, so long streaks report once.
    always_comb begin
        restart = (run_q == 4'd0) || (run_class_q != best_idx_q);
        if (!pass)
            run_d = 4'd0;
        else if (restart)
            run_d = 4'd1;
        else if (run_q != 4'hF)
            run_d = run_q + 4'd1;
        else
            run_d = run_q;
        emit = pass && (run_d == 4'(VOTE_FRAMES)) && (restart || run_q != 4'(VOTE_FRAMES));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q       <= '0;
            run_class_q <= '0;
        end else if (state_q == DECIDE) begin
            run_q       <= run_d;
            run_class_q <= best_idx_q;
        end
    end
`else
    assign emit = pass;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            vld_q           <= '0;
            energy_q        <= '0;
            best_q          <= '0;
            runner_q        <= '0;
            best_idx_q      <= '0;
            result_valid_q  <= 1'b0;
            frame_dropped_q <= 1'b0;
            class_q         <= '0;
            margin_q        <= '0;
            energy_out_q    <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc_q[k]    <= '0;
                scores_q[k] <= '0;
            end
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            vld_q           <= READ_LATENCY'({vld_q, feat_rd_en_o});
            frame_dropped_q <= frame_tick_i && (state_q != IDLE);
            result_valid_q  <= (state_q == DECIDE) && emit;

            // Published scores follow the accumulators beat by beat, so they keep last frame's values until new data lands.
            if (state_q == IDLE && frame_tick_i) begin
                energy_q <= '0;
                for (int k = 0; k < NUM_CLASSES; k++) acc_q[k] <= '0;
            end else if (vld_q[READ_LATENCY-1]) begin
                energy_q <= energy_d;
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    acc_q[k]    <= acc_d[k];
                    scores_q[k] <= acc_d[k];
                end
            end

            if (state_q == ARGMAX) begin
                if (cnt_q == '0) begin
                    best_q     <= cur_score;
                    best_idx_q <= '0;
                    runner_q   <= SCORE_MIN;
                end else if (cur_score > best_q) begin
                    runner_q   <= best_q;
                    best_q     <= cur_score;
                    best_idx_q <= cur_idx;
                end else if (cur_score > runner_q) begin
                    runner_q   <= cur_score;
                end
            end

            if (state_q == DECIDE && emit) begin
                class_q      <= best_idx_q;
                margin_q     <= margin;
                energy_out_q <= energy_q;
            end
        end
    end

    always_comb begin
        scores_flat_o = '0;
        for (int k = 0; k < NUM_CLASSES; k++) scores_flat_o[k*SCORE_BITS +: SCORE_BITS] = scores_q[k];
    end

    assign busy_o          = (state_q != IDLE);
    assign feat_rd_en_o    = (state_q == SCAN);
    assign feat_addr_o     = feat_rd_en_o ? cnt_q : '0;
    assign w_addr_o        = feat_addr_o;
    assign result_valid_o  = result_valid_q;
    assign result_class_o  = class_q;
    assign result_margin_o = margin_q;
    assign result_energy_o = energy_out_q;
    assign frame_dropped_o = frame_dropped_q;

endmodule

// File: tb/tb_frame_score_classifier.sv
// Directed bench: default-parameter instance plus a SCORE_BITS=16 / MIN_MARGIN=0 instance fed the same stream.
module tb_frame_score_classifier;

    localparam int L = 264;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [7:0]  feat_data;
    logic [31:0] w_flat;
    logic [7:0]  featVal;
    logic signed [7:0] wVal [4];
    logic [1:0]  pipeV;

    logic        busyA, rdA, validA, dropA;
    logic [7:0]  addrA, waddrA;
    logic [1:0]  classA;
    logic [23:0] marginA, energyA;
    logic [95:0] scoresA;

    logic        busyB, rdB, validB, dropB;
    logic [7:0]  addrB, waddrB;
    logic [1:0]  classB;
    logic [15:0] marginB;
    logic [23:0] energyB;
    logic [63:0] scoresB;

    int numChecks = 0;
    int numFails  = 0;
    int pulseCount;

    always #5 clk = ~clk;

    frame_score_classifier dutA (
        .clk(clk), .rst(rst), .frame_tick_i(tick), .busy_o(busyA),
        .feat_addr_o(addrA), .feat_rd_en_o(rdA), .feat_data_i(feat_data),
        .w_addr_o(waddrA), .w_data_flat_i(w_flat), .result_valid_o(validA),
        .result_class_o(classA), .result_margin_o(marginA), .result_energy_o(energyA),
        .scores_flat_o(scoresA), .frame_dropped_o(dropA)
    );

    frame_score_classifier #(.SCORE_BITS(16), .MIN_MARGIN(0)) dutB (
        .clk(clk), .rst(rst), .frame_tick_i(tick), .busy_o(busyB),
        .feat_addr_o(addrB), .feat_rd_en_o(rdB), .feat_data_i(feat_data),
        .w_addr_o(waddrB), .w_data_flat_i(w_flat), .result_valid_o(validB),
        .result_class_o(classB), .result_margin_o(marginB), .result_energy_o(energyB),
        .scores_flat_o(scoresB), .frame_dropped_o(dropB)
    );

    // Two-cycle read model; data outside a valid beat is garbage so extra or missing beats show up in the scores.
    always @(posedge clk) pipeV <= {pipeV[0], rdA};

    always_comb begin
        feat_data = pipeV[1] ? featVal : 8'hA5;
        w_flat    = pipeV[1] ? {wVal[3], wVal[2], wVal[1], wVal[0]} : 32'h5A5A5A5A;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numChecks++;
        assert (observed === expected) else begin
            numFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setVectors(input logic [7:0] f, input logic signed [7:0] w0, input logic signed [7:0] w1,
                              input logic signed [7:0] w2, input logic signed [7:0] w3);
        featVal = f;
        wVal[0] = w0;
        wVal[1] = w1;
        wVal[2] = w2;
        wVal[3] = w3;
    endtask

    // Holds tick for one cycle; returns one cycle after the accepting edge.
    task automatic applyStimulus();
        tick = 1'b1;
        waitCycles(1);
        tick = 1'b0;
    endtask

    task automatic runToResult(input int atCycle, input logic expA, input logic expB);
        waitCycles(L - 1 - atCycle);
        checkOutput("validA before latency", validA, 0);
        checkOutput("busyA before latency", busyA, 1);
        waitCycles(1);
        checkOutput("validA at latency", validA, expA);
        checkOutput("validB at latency", validB, expB);
        checkOutput("busyA falls", busyA, 0);
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        setVectors(8'd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
        waitCycles(2);
        rst = 1'b0;
        checkOutput("reset busy", busyA, 0);
        checkOutput("reset valid", validA, 0);
        checkOutput("reset rd_en", rdA, 0);
        checkOutput("reset class", classA, 0);
        checkOutput("reset dropped", dropA, 0);
        checkOutput("reset scores", scoresA[63:0], 0);

`ifdef FSC_VOTE_EN
        begin
            int frameClass [7] = '{1, 1, 2, 2, 2, 2, 2};
            logic expPulse [7] = '{0, 0, 0, 0, 1, 0, 0};
            for (int f = 0; f < 7; f++) begin
                if (frameClass[f] == 1) setVectors(8'd1, 8'sd0, 8'sd1, 8'sd0, 8'sd0);
                else                    setVectors(8'd1, 8'sd0, 8'sd0, 8'sd1, 8'sd0);
                applyStimulus();
                runToResult(1, expPulse[f], expPulse[f]);
                if (f == 4) begin
                    checkOutput("vote class", classA, 2);
                    checkOutput("vote margin", marginA, 256);
                end
            end
        end
`else
        // Single class with positive weight.
        setVectors(8'd1, 8'sd0, 8'sd0, 8'sd2, 8'sd0);
        applyStimulus();
        checkOutput("t1 busy", busyA, 1);
        checkOutput("t1 rd_en", rdA, 1);
        checkOutput("t1 first addr", addrA, 0);
        checkOutput("t1 w_addr", waddrA, 0);
        waitCycles(1);
        checkOutput("t1 second addr", addrA, 1);
        runToResult(2, 1'b1, 1'b1);
        checkOutput("t1 class", classA, 2);
        checkOutput("t1 margin", marginA, 512);
        checkOutput("t1 energy", energyA, 256);
        checkOutput("t1 score2", scoresA[48 +: 24], 512);
        checkOutput("t1 score0", scoresA[0 +: 24], 0);
        checkOutput("t1 B class", classB, 2);
        checkOutput("t1 B score2", scoresB[32 +: 16], 512);

        // Zero energy is gated out; previous result holds.
        setVectors(8'd0, 8'sd0, 8'sd0, 8'sd2, 8'sd0);
        applyStimulus();
        checkOutput("t2 valid single pulse", validA, 0);
        runToResult(1, 1'b0, 1'b0);
        checkOutput("t2 class held", classA, 2);
        checkOutput("t2 margin held", marginA, 512);
        checkOutput("t2 energy held", energyA, 256);
        checkOutput("t2 score2 final", scoresA[48 +: 24], 0);

        // Exact tie between classes 1 and 3: margin 0.
        setVectors(8'd4, 8'sd0, 8'sd1, 8'sd0, 8'sd1);
        applyStimulus();
        runToResult(1, 1'b0, 1'b1);
        checkOutput("t3 A class held", classA, 2);
        checkOutput("t3 B tie class", classB, 1);
        checkOutput("t3 B margin", marginB, 0);
        checkOutput("t3 B energy", energyB, 1024);

        // Tick while busy is dropped; tick on the result cycle is accepted.
        setVectors(8'd1, 8'sd3, 8'sd0, 8'sd0, 8'sd0);
        applyStimulus();
        waitCycles(9);
        tick = 1'b1;
        waitCycles(1);
        tick = 1'b0;
        checkOutput("t4 dropped pulse", dropA, 1);
        checkOutput("t4 still busy", busyA, 1);
        waitCycles(1);
        checkOutput("t4 dropped one cycle", dropA, 0);
        runToResult(12, 1'b1, 1'b1);
        checkOutput("t4 class", classA, 0);
        checkOutput("t4 margin", marginA, 768);
        checkOutput("t4 energy", energyA, 256);
        applyStimulus();
        checkOutput("t4 back-to-back busy", busyA, 1);
        checkOutput("t4 back-to-back not dropped", dropA, 0);
        checkOutput("t4 back-to-back addr", addrA, 0);
        runToResult(1, 1'b1, 1'b1);
        checkOutput("t4 second class", classA, 0);

        // Saturation in both directions on the 16-bit instance.
        setVectors(8'd255, 8'sd127, -8'sd128, 8'sd0, 8'sd0);
        applyStimulus();
        runToResult(1, 1'b1, 1'b1);
        checkOutput("t5 B score0 sat", scoresB[0 +: 16], 16'h7FFF);
        checkOutput("t5 B score1 sat", scoresB[16 +: 16], 16'h8000);
        checkOutput("t5 B margin", marginB, 16'h7FFF);
        checkOutput("t5 B energy", energyB, 65280);
        checkOutput("t5 A score0", scoresA[0 +: 24], 24'h7E8100);
        checkOutput("t5 A score1", scoresA[24 +: 24], 24'h808000);
        checkOutput("t5 A margin", marginA, 24'h7E8100);

        // Reset mid-frame: 97 beats accumulated at T+100, then abort.
        setVectors(8'd255, 8'sd127, 8'sd0, 8'sd0, 8'sd0);
        applyStimulus();
        waitCycles(99);
        checkOutput("t5 B mid sat", scoresB[0 +: 16], 16'h7FFF);
        checkOutput("t5 A mid score", scoresA[0 +: 24], 24'h2FEEE1);
        rst = 1'b1;
        #1;
        checkOutput("t5 rst busy", busyA, 0);
        checkOutput("t5 rst class", classA, 0);
        checkOutput("t5 rst margin", marginA, 0);
        checkOutput("t5 rst energy", energyA, 0);
        checkOutput("t5 rst scores zero", scoresA == '0, 1);
        waitCycles(1);
        rst = 1'b0;
        pulseCount = 0;
        for (int i = 0; i < L + 10; i++) begin
            waitCycles(1);
            if (validA) pulseCount++;
        end
        checkOutput("t5 no result after rst", pulseCount, 0);
        checkOutput("t5 idle after rst", busyA, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/frame_score_classifier.md
Name: frame_score_classifier

Overview:
- Parametrised successor to the fixed 4-class gradient-map classifier.
- On each frame tick it streams all NUM_CELLS feature cells from the time-surface BRAM, together with per-class weights, through NUM_CLASSES parallel saturating MACs.
- It then runs a sequential argmax/runner-up search and gates the result on energy and score margin.
- An optional consecutive-frame vote sits before the result port, which feeds the UART/LED reporting logic.

Parameters:
NUM_CELLS, 256, feature cells per frame (power of 2, 16..4096)
NUM_CLASSES, 4, output classes (2..16)
VALUE_BITS, 8, unsigned feature width
WEIGHT_BITS, 8, signed weight width
SCORE_BITS, 24, signed accumulator width
ENERGY_BITS, 24, unsigned energy accumulator width
READ_LATENCY, 2, cycles from address to feature/weight data (1..4)
MIN_ENERGY, 100, energy gate threshold
MIN_MARGIN, 16, best minus runner-up gate threshold
VOTE_FRAMES, 3, consecutive agreeing frames required (vote mode only, 1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
frame_tick  in  1  single-cycle frame request
busy  out  1  high from the cycle after an accepted tick until result decision completes
feat_addr  out  $clog2(NUM_CELLS)  feature read address
feat_rd_en  out  1  feature read strobe
feat_data  in  VALUE_BITS  feature data, READ_LATENCY cycles after feat_addr/feat_rd_en
w_addr  out  $clog2(NUM_CELLS)  weight address, always equal to feat_addr
w_data_flat  in  NUM_CLASSES*WEIGHT_BITS  weights; class k occupies bits [k*WEIGHT_BITS +: WEIGHT_BITS]; same latency as feat_data
result_valid  out  1  one-cycle result pulse
result_class  out  max(1,$clog2(NUM_CLASSES))  winning class
result_margin  out  SCORE_BITS  best minus runner-up score, non-negative
result_energy  out  ENERGY_BITS  frame energy
scores_flat  out  NUM_CLASSES*SCORE_BITS  final scores, held until the next frame's first accumulate
frame_dropped  out  1  one-cycle pulse when a tick arrives while busy

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; accumulators, energy and vote state cleared. Reset mid-frame aborts the frame with no result.
- FSM: IDLE -> SCAN -> DRAIN -> ARGMAX -> DECIDE -> IDLE.
- IDLE: frame_tick sampled at edge T moves to SCAN. At that edge all score and energy accumulators clear.
- SCAN: feat_rd_en=1 and feat_addr = 0..NUM_CELLS-1 on consecutive cycles T+1..T+NUM_CELLS; then DRAIN.
- DRAIN: lasts READ_LATENCY cycles.
- Accumulate: valid data is tracked by a READ_LATENCY-deep valid shift register, not by address compare.
  - Per valid beat, score[k] += signed(w_k) * zero-extended feat_data, saturating at the SCORE_BITS signed range.
  - energy += feat_data, saturating at 2^ENERGY_BITS-1.
- ARGMAX: NUM_CLASSES cycles, visiting one class per cycle in index order.
  - A strictly-greater comparison sets best, so ties resolve to the lowest index.
  - Runner-up is tracked separately; for an exact tie, margin = 0.
- DECIDE: one cycle. pass = (energy >= MIN_ENERGY) && (margin >= MIN_MARGIN).
- Latency: result_valid is high at cycle T+L, with L = NUM_CELLS + READ_LATENCY + NUM_CLASSES + 2. busy falls in the same cycle.
- frame_tick while busy (including the DECIDE cycle): ignored, frame_dropped pulses 1 cycle, and the current frame is unaffected. A tick in the same cycle result_valid rises is accepted.
- Outputs result_class/margin/energy hold their last value between pulses. On a gated-out frame no pulse occurs and the outputs are unchanged.

Optional Feature:
Macro FSC_VOTE_EN.
- Defined:
  - A run counter (4 bits, saturating) tracks consecutive passing frames with the same class.
  - A failing frame or a class change resets the run; a class change starts a new run at 1.
  - result_valid pulses only in the frame where the run reaches exactly VOTE_FRAMES. Further identical frames do not re-pulse until the run is broken.
  - Reset clears the run.
- Undefined: every passing frame pulses result_valid, and no run counter is synthesised.

Test Plan:
1. Defaults, feature=1 at all cells, class-2 weights=+2, others 0; tick at T -> result_valid at T+264, class=2, margin=512, energy=256, scores_flat class2=512.
2. Uniform feature=0 -> energy=0 < 100 -> no result_valid; busy still falls at T+264; outputs from the previous frame are unchanged.
3. Classes 1 and 3 with identical weights +1, feature=4 -> best=1 (tie to lower index), margin=0 < 16 -> no pulse; with MIN_MARGIN=0, pulse with class=1.
4. Second tick 10 cycles after the first -> frame_dropped pulses once; first frame's result at T+264 is unchanged; a tick exactly at T+264 is accepted.
5. Weights +127, feature=255, SCORE_BITS=16 -> score saturates at 32767 (no wrap); rst asserted at T+100 -> outputs 0 immediately, no result_valid.
6. FSC_VOTE_EN, VOTE_FRAMES=3: frames classified 1,1,2,2,2,2 (all passing) -> single pulse on frame 5 with class=2; a 7th class-2 frame produces no pulse.
